// File: rtl/icache_lite_if.sv
// Fetch-side and refill-side signals of icache_lite, grouped for the port list.
// The cache uses the slave modport; the fetch unit/memory side uses master.
interface icache_lite_if #(
    parameter int unsigned XLEN = 32
);
    logic            adr_v_i;
    logic [XLEN-1:0] adr_i;
    logic [31:0]     instr_o;
    logic            stall_o;
    logic            flush_i;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_rdata_v_i;
    logic [31:0]     mem_rdata_i;

    modport master (
        output adr_v_i, adr_i, flush_i, mem_rdata_v_i, mem_rdata_i,
        input  instr_o, stall_o, mem_req_o, mem_adr_o
    );

    modport slave (
        input  adr_v_i, adr_i, flush_i, mem_rdata_v_i, mem_rdata_i,
        output instr_o, stall_o, mem_req_o, mem_adr_o
    );
endinterface

// File: rtl/icache_lite.sv
// Direct-mapped read-only instruction cache: combinational hits, stall on miss while
// a fixed-length line is refilled beat by beat from instruction memory.
module icache_lite #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NB_LINES       = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    icache_lite_if.slave    bus
);
    localparam int unsigned WordBits = $clog2(WORDS_PER_LINE);
    localparam int unsigned IdxBits  = $clog2(NB_LINES);
    localparam int unsigned OffBits  = 2 + WordBits;
    localparam int unsigned TagBits  = XLEN - OffBits - IdxBits;

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    state_e state_q, state_d;

    logic [NB_LINES-1:0] valid_q;
    logic [TagBits-1:0]  tag_q  [NB_LINES];
    logic [31:0]         data_q [NB_LINES][WORDS_PER_LINE];

    logic [TagBits-1:0]  line_tag_q;
    logic [IdxBits-1:0]  line_idx_q;
    logic [WordBits-1:0] cnt_q;
    logic                flush_pend_q;

    logic [WordBits-1:0] adr_word;
    logic [IdxBits-1:0]  adr_idx;
    logic [TagBits-1:0]  adr_tag;
    logic                unused_adr_bits;

    logic hit;
    logic start_refill;
    logic beat_we;
    logic refill_done;

    assign adr_word        = bus.adr_i[2 +: WordBits];
    assign adr_idx         = bus.adr_i[OffBits +: IdxBits];
    assign adr_tag         = bus.adr_i[XLEN-1 -: TagBits];
    assign unused_adr_bits = ^bus.adr_i[1:0];

    always_comb begin
        hit          = bus.adr_v_i && valid_q[adr_idx] && (tag_q[adr_idx] == adr_tag)
                       && (state_q == StIdle);
        start_refill = 1'b0;
        beat_we      = 1'b0;
        refill_done  = 1'b0;
        state_d      = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.adr_v_i && !hit) begin
                    start_refill = 1'b1;
                    state_d      = StRefill;
                end
            end
            StRefill: begin
                if (bus.mem_rdata_v_i) begin
                    beat_we = 1'b1;
                    if (cnt_q == WordBits'(WORDS_PER_LINE - 1)) begin
                        refill_done = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.instr_o   = hit ? data_q[adr_idx][adr_word] : 32'h0;
    assign bus.stall_o   = bus.adr_v_i && !hit;
    assign bus.mem_req_o = (state_q == StRefill);
    assign bus.mem_adr_o = bus.mem_req_o ? {line_tag_q, line_idx_q, {OffBits{1'b0}}} : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start_refill) begin
                cnt_q <= '0;
            end else if (beat_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (start_refill) begin
                flush_pend_q <= 1'b0;
            end else if (bus.flush_i && state_q == StRefill) begin
                flush_pend_q <= 1'b1;
            end
            if (bus.flush_i) begin
                valid_q <= '0;
            end
            // The victim is invalidated up front so a half-written line never hits.
            if (start_refill) begin
                valid_q[adr_idx] <= 1'b0;
            end
            if (refill_done) begin
                valid_q[line_idx_q] <= !flush_pend_q && !bus.flush_i;
            end
        end
    end

    // Line address, tags and data carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (start_refill) begin
            line_tag_q <= adr_tag;
            line_idx_q <= adr_idx;
        end
        if (beat_we) begin
            data_q[line_idx_q][cnt_q] <= bus.mem_rdata_i;
        end
        if (refill_done) begin
            tag_q[line_idx_q] <= line_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_lite.sv
// Randomized scoreboard bench for icache_lite: a line-level cache model predicts hits,
// refill addresses and returned words; a monitor checks what the DUT presents.
module tb_icache_lite;
    localparam int unsigned NL = 16;
    localparam int unsigned W  = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    icache_lite_if #(.XLEN(32)) bus ();

    icache_lite #(
        .XLEN          (32),
        .NB_LINES      (NL),
        .WORDS_PER_LINE(W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [31:0] instr;
        bit          miss;
        bit          timing;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] adr_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Reference model: which line address each index currently holds.
    bit          m_valid[NL];
    logic [31:0] m_line[NL];

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // Memory responder: beats only while a refill is requested, with configurable gaps.
    int gap_lo = 0, gap_hi = 0, beats_issued = 0, gap_left = 0;
    bit stray_en = 1'b0;
    initial begin
        bus.mem_rdata_v_i = 1'b0;
        bus.mem_rdata_i   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req_o) begin
                if (gap_left > 0) begin
                    gap_left--;
                    bus.mem_rdata_v_i = 1'b0;
                end else begin
                    bus.mem_rdata_v_i = 1'b1;
                    bus.mem_rdata_i   = memf(bus.mem_adr_o + (32'(beats_issued) << 2));
                    beats_issued++;
                    gap_left = $urandom_range(gap_hi, gap_lo);
                end
            end else begin
                beats_issued      = 0;
                gap_left          = 0;
                bus.mem_rdata_v_i = stray_en;
                bus.mem_rdata_i   = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops expectations when a fetch is accepted or a refill begins.
    int          stall_cnt = 0, req_cnt = 0, beat_cnt = 0;
    bit          req_prev = 1'b0, skip_beats = 1'b0;
    logic [31:0] cur_adr = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!bus.adr_v_i) begin
            check("idle_stall", 32'(bus.stall_o), 32'h0);
            check("idle_instr", bus.instr_o, 32'h0);
            stall_cnt = 0;
            req_cnt   = 0;
        end else if (bus.stall_o) begin
            stall_cnt++;
            if (bus.mem_req_o) req_cnt++;
        end else begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_accept: got adr %h expected no accept", bus.adr_i);
            end else begin
                e = exp_q.pop_front();
                check("instr", bus.instr_o, e.instr);
                if (e.timing) begin
                    if (e.miss) begin
                        check("miss_stall", 32'(stall_cnt), 32'(req_cnt + 1));
                        check("miss_req_len", 32'(req_cnt >= int'(W)), 32'h1);
                    end else begin
                        check("hit_stall", 32'(stall_cnt), 32'h0);
                    end
                end
            end
            stall_cnt = 0;
            req_cnt   = 0;
        end

        if (!bus.mem_req_o) check("adr_when_no_req", bus.mem_adr_o, 32'h0);
        if (bus.mem_req_o && !req_prev) begin
            beat_cnt = 0;
            if (adr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_refill: got %h expected no refill", bus.mem_adr_o);
                cur_adr = bus.mem_adr_o;
            end else begin
                cur_adr = adr_q.pop_front();
            end
        end
        if (bus.mem_req_o) begin
            check("mem_adr", bus.mem_adr_o, cur_adr);
            if (bus.mem_rdata_v_i) beat_cnt++;
        end
        if (!bus.mem_req_o && req_prev) begin
            if (!skip_beats) check("refill_beats", 32'(beat_cnt), 32'(W));
            skip_beats = 1'b0;
        end
        req_prev = bus.mem_req_o;
    end

    task automatic wait_accept(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.stall_o) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got stall_o=1 for 300 cycles expected accept", name);
        summary();
    endtask

    task automatic wait_req(input logic level);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.mem_req_o == level) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL req_timeout: got mem_req_o=%b expected %b", !level, level);
        summary();
    endtask

    task automatic fetch(input logic [31:0] a, input int idle_after);
        int          idx;
        logic [31:0] line;
        bit          hit;
        idx  = int'((a >> 4) % NL);
        line = a & ~32'(W * 4 - 1);
        hit  = m_valid[idx] && (m_line[idx] == line);
        exp_q.push_back(exp_t'{memf(a), !hit, 1'b1});
        if (!hit) adr_q.push_back(line);
        m_valid[idx] = 1'b1;
        m_line[idx]  = line;
        bus.adr_v_i  = 1'b1;
        bus.adr_i    = a;
        wait_accept("fetch");
        @(posedge clk);
        #1;
        if (idle_after > 0) begin
            bus.adr_v_i = 1'b0;
            bus.adr_i   = $urandom;
            repeat (idle_after) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic flush_pulse();
        bus.adr_v_i = 1'b0;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        model_clear();
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.adr_v_i = 1'b0;
        bus.adr_i   = '0;
        bus.flush_i = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        // Outputs while held in reset: every valid access misses.
        bus.adr_v_i = 1'b1;
        bus.adr_i   = 32'h104;
        @(negedge clk);
        check("reset_stall", 32'(bus.stall_o), 32'h1);
        check("reset_instr", bus.instr_o, 32'h0);
        check("reset_req", 32'(bus.mem_req_o), 32'h0);
        @(posedge clk);
        #1;
        bus.adr_v_i = 1'b0;
        reset_n     = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Cold miss, then a hit in the same line; conflict on index 0.
        fetch(32'h104, 1);
        fetch(32'h10C, 1);
        fetch(32'h1100, 0);
        fetch(32'h1100, 0);
        fetch(32'h100, 1);

        // Gapped beats with the fetch address switched away and back mid-refill.
        gap_lo = 2;
        gap_hi = 2;
        exp_q.push_back(exp_t'{memf(32'h200), 1'b1, 1'b1});
        adr_q.push_back(32'h200);
        m_valid[0]  = 1'b1;
        m_line[0]   = 32'h200;
        bus.adr_v_i = 1'b1;
        bus.adr_i   = 32'h200;
        repeat (4) @(posedge clk);
        #1;
        bus.adr_i = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        bus.adr_i = 32'h200;
        wait_accept("gapped");
        @(posedge clk);
        #1;
        bus.adr_v_i = 1'b0;
        gap_lo = 0;
        gap_hi = 0;
        fetch(32'h300, 1);

        // Flush while idle.
        fetch(32'h100, 0);
        fetch(32'h104, 1);
        flush_pulse();
        fetch(32'h100, 1);

        // Flush during a refill whose fetch was abandoned: line must stay invalid.
        adr_q.push_back(32'h200);
        bus.adr_v_i = 1'b1;
        bus.adr_i   = 32'h200;
        wait_req(1'b1);
        @(posedge clk);
        #1;
        bus.adr_v_i = 1'b0;
        flush_pulse();
        wait_req(1'b0);
        @(posedge clk);
        #1;
        fetch(32'h200, 1);

        // Reset after two of four beats; stray beats in idle must be ignored.
        exp_q.push_back(exp_t'{memf(32'h100), 1'b1, 1'b0});
        adr_q.push_back(32'h100);
        adr_q.push_back(32'h100);
        bus.adr_v_i = 1'b1;
        bus.adr_i   = 32'h100;
        for (int i = 0; i < 50 && beats_issued < 2; i++) begin
            @(posedge clk);
            #3;
        end
        @(posedge clk);
        #1;
        reset_n    = 1'b0;
        skip_beats = 1'b1;
        stray_en   = 1'b1;
        @(posedge clk);
        #1;
        check("req_after_reset", 32'(bus.mem_req_o), 32'h0);
        reset_n = 1'b1;
        model_clear();
        m_valid[0] = 1'b1;
        m_line[0]  = 32'h100;
        @(posedge clk);
        #1;
        stray_en = 1'b0;
        wait_accept("reset_refill");
        @(posedge clk);
        #1;
        bus.adr_v_i = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic over a few tags to force conflicts and back-to-back misses.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 19) == 0) flush_pulse();
            gap_hi = $urandom_range(0, 3);
            a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom)};
            fetch(a, $urandom_range(0, 1));
        end

        bus.adr_v_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        check("adr_queue_drained", 32'(adr_q.size()), 32'h0);
        summary();
    end
endmodule
